// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one memory-mapped UART transmitter between NREQ byte producers.
// A round-robin pointer picks the next requester; the bus sequencer then
// enables the UART once after reset, polls STAT until the transmitter is
// free, writes the byte to TXDT and leaves one settle cycle before the next
// arbitration. All bus outputs and the req_ready pulses are registered.
module uart_tx_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] BASE_ADDR = 32'hffff0020,
    parameter logic [31:0] CTRL_INIT = 32'h2,
    parameter int          TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      bus_we,
    output logic [31:0]               bus_addr,
    output logic [31:0]               bus_wdata,
    input  logic [31:0]               bus_rdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int PCNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [31:0] TXDT_ADDR = BASE_ADDR + 32'h4;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'h8;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'hc;

    localparam logic [PCNT_W-1:0] POLL_LAST  = PCNT_W'(TIMEOUT - 1);
    localparam logic [ID_W:0]     NREQ_WIDE  = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NREQ - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_POLL,
        S_WRITE,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic                bus_we_q, bus_we_d;
    logic [31:0]         bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [NREQ-1:0]     req_ready_q, req_ready_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [7:0]          byte_q, byte_d;

    logic [NREQ-1:0]     eligible;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W:0]       scan_idx;
    logic [ID_W-1:0]     next_ptr;
    logic [NREQ-1:0]     grant_onehot;
    logic                stat_tx_busy;
    logic                unused_rdata;

    // A requester whose req_ready pulse is on the wire this cycle has not yet
    // had the chance to drop req_valid, so it must not be granted again.
    assign eligible = req_valid & ~req_ready_q;

    assign next_ptr     = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
    assign grant_onehot = NREQ'(1) << grant_id_q;

    assign stat_tx_busy = bus_rdata[1];
    assign unused_rdata = ^{bus_rdata[31:2], bus_rdata[0]};

    // Round-robin search: first eligible requester at or after rr_ptr (mod NREQ).
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= NREQ_WIDE) begin
                scan_idx = scan_idx - NREQ_WIDE;
            end
            if (eligible[scan_idx[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // Next state plus the registered output values for the state being entered.
    always_comb begin
        state_d       = state_q;
        bus_we_d      = 1'b0;
        bus_addr_d    = STAT_ADDR;
        bus_wdata_d   = '0;
        req_ready_d   = '0;
        grant_id_d    = grant_id_q;
        busy_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        rr_ptr_d      = rr_ptr_q;
        poll_cnt_d    = poll_cnt_q;
        byte_d        = byte_q;

        unique case (state_q)
            S_INIT: begin
                // Reset parks here with the bus quiet; the first clock after
                // release presents the CTRL write, the second moves on.
                if (!bus_we_q) begin
                    state_d     = S_INIT;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = CTRL_ADDR;
                    bus_wdata_d = CTRL_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_POLL;
                    grant_id_d = pick_id;
                    byte_d     = req_data[{pick_id, 3'b000} +: 8];
                    poll_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end

            S_POLL: begin
                if (!stat_tx_busy) begin
                    state_d     = S_WRITE;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = TXDT_ADDR;
                    bus_wdata_d = {24'b0, byte_q};
                    req_ready_d = grant_onehot;
                    rr_ptr_d    = next_ptr;
                    poll_cnt_d  = '0;
                    busy_d      = 1'b1;
                end else if (poll_cnt_q == POLL_LAST) begin
                    // Transmitter never freed up: release the requester and
                    // drop its byte so the others are not blocked forever.
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    req_ready_d   = grant_onehot;
                    rr_ptr_d      = next_ptr;
                    poll_cnt_d    = '0;
                end else begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                    busy_d     = 1'b1;
                end
            end

            S_WRITE: begin
                state_d = S_GAP;
                busy_d  = 1'b1;
            end

            S_GAP: begin
                // One quiet cycle so STAT reflects the byte just written
                // before the next poll reads it.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (!rst) begin
            state_q       <= S_INIT;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            req_ready_q   <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rr_ptr_q      <= '0;
            poll_cnt_q    <= '0;
            byte_q        <= '0;
        end else begin
            state_q       <= state_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            req_ready_q   <= req_ready_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            rr_ptr_q      <= rr_ptr_d;
            poll_cnt_q    <= poll_cnt_d;
            byte_q        <= byte_d;
        end
    end

    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign req_ready   = req_ready_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
